// File: rtl/usb_fs_out_arb_rr.sv
// Round-robin arbiter sharing the OUT endpoint read port among NUM_OUT_EPS consumers.
// Grant is registered, gets are masked by grant, and data_valid follows a get by one cycle.
module usb_fs_out_arb_rr #(
    parameter int NUM_OUT_EPS = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_OUT_EPS-1:0] req,
    input  logic [NUM_OUT_EPS-1:0] data_get,
    output logic [NUM_OUT_EPS-1:0] out_ep_grant,
    output logic [NUM_OUT_EPS-1:0] out_ep_data_get,
    output logic [NUM_OUT_EPS-1:0] data_valid,
    output logic [3:0]             grant_num,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [3:0] LAST_EP = 4'(NUM_OUT_EPS - 1);

    state_t                 state;
    logic [3:0]             ptr;
    logic [3:0]             sel_idx;
    logic                   sel_hit;
    int                     idx;
    logic [NUM_OUT_EPS-1:0] req_rot;

    // First requester at or after ptr; scanning downward so the lowest offset wins.
    always_comb begin
        sel_idx = '0;
        sel_hit = 1'b0;
        idx     = 0;
        req_rot = '0;
        for (int k = NUM_OUT_EPS - 1; k >= 0; k--) begin
            idx     = (int'(ptr) + k) % NUM_OUT_EPS;
            req_rot = req >> idx;
            if (req_rot[0]) begin
                sel_hit = 1'b1;
                sel_idx = 4'(idx);
            end
        end
    end

    assign out_ep_data_get = data_get & out_ep_grant;
    assign busy            = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= '0;
            out_ep_grant <= '0;
            grant_num    <= '0;
            data_valid   <= '0;
        end else begin
            // The engine's read is registered, so valid trails the forwarded get by one cycle.
            data_valid <= out_ep_data_get;
            case (state)
                IDLE: begin
                    if (sel_hit) begin
                        out_ep_grant <= NUM_OUT_EPS'(1) << sel_idx;
                        grant_num    <= sel_idx;
                        state        <= GRANTED;
                    end
                end
                GRANTED: begin
                    if ((req & out_ep_grant) == '0) begin
                        out_ep_grant <= '0;
                        grant_num    <= '0;
                        ptr          <= (grant_num == LAST_EP) ? 4'd0 : grant_num + 4'd1;
                        state        <= RELEASE;
                    end
                end
                RELEASE: begin
                    // One dead cycle drains the last read before the next owner is chosen.
                    state <= IDLE;
                end
                default: begin
                    state        <= IDLE;
                    out_ep_grant <= '0;
                    grant_num    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_fs_out_arb_rr.sv
// Directed bench for usb_fs_out_arb_rr: a 4-endpoint instance and a 1-endpoint instance.
module tb_usb_fs_out_arb_rr;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] data_get = '0;
    logic [3:0] out_ep_grant, out_ep_data_get, data_valid, grant_num;
    logic       busy;

    logic [0:0] req1 = '0;
    logic [0:0] data_get1 = '0;
    logic [0:0] grant1, odg1, dv1;
    logic [3:0] gn1;
    logic       busy1;

    int total = 0;
    int bad = 0;
    logic armed = 1'b0;

    always #5 clk = ~clk;

    usb_fs_out_arb_rr #(.NUM_OUT_EPS(4)) u4 (
        .clk(clk), .reset(reset), .req(req), .data_get(data_get),
        .out_ep_grant(out_ep_grant), .out_ep_data_get(out_ep_data_get),
        .data_valid(data_valid), .grant_num(grant_num), .busy(busy)
    );

    usb_fs_out_arb_rr #(.NUM_OUT_EPS(1)) u1 (
        .clk(clk), .reset(reset), .req(req1), .data_get(data_get1),
        .out_ep_grant(grant1), .out_ep_data_get(odg1),
        .data_valid(dv1), .grant_num(gn1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drop to new_req on the current owner: two idle cycles, then the next grant.
    task automatic rotate(input logic [3:0] new_req, input logic [3:0] exp_grant, input logic [3:0] exp_num);
        req = new_req;
        tick();
        chk("rot_release_grant", out_ep_grant, 4'b0000);
        chk("rot_release_busy", 4'(busy), 4'd1);
        tick();
        chk("rot_idle_grant", out_ep_grant, 4'b0000);
        chk("rot_idle_busy", 4'(busy), 4'd0);
        tick();
        chk("rot_grant", out_ep_grant, exp_grant);
        chk("rot_grant_num", grant_num, exp_num);
    endtask

    // Structural properties sampled on the falling edge.
    always @(negedge clk) begin
        if (armed) begin
            chk("grant_onehot0", 4'($onehot0(out_ep_grant)), 4'd1);
            chk("grant_num_match", (out_ep_grant == 4'b0) ? grant_num : out_ep_grant,
                (out_ep_grant == 4'b0) ? 4'd0 : 4'(4'b0001 << grant_num));
            chk("odg_subset", out_ep_data_get & ~out_ep_grant, 4'b0000);
            chk("dv_onehot0", 4'($onehot0(data_valid)), 4'd1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state with every request high
        req = 4'b1111;
        tick();
        tick();
        armed = 1'b1;
        chk("rst_grant", out_ep_grant, 4'b0000);
        chk("rst_dv", data_valid, 4'b0000);
        chk("rst_num", grant_num, 4'd0);
        chk("rst_busy", 4'(busy), 4'd0);
        chk("rst_odg", out_ep_data_get, 4'b0000);

        reset = 1'b0;
        tick();
        chk("first_grant", out_ep_grant, 4'b0001);
        chk("first_num", grant_num, 4'd0);
        chk("first_busy", 4'(busy), 4'd1);

        // Strict rotation with wrap
        rotate(4'b1110, 4'b0010, 4'd1);
        rotate(4'b1101, 4'b0100, 4'd2);
        rotate(4'b1011, 4'b1000, 4'd3);
        rotate(4'b0111, 4'b0001, 4'd0);

        // EP1 granted, three consecutive gets
        rotate(4'b1110, 4'b0010, 4'd1);
        for (int i = 0; i < 4; i++) begin
            data_get = (i < 3) ? 4'b0010 : 4'b0000;
            #1;
            chk("burst_odg", out_ep_data_get, (i < 3) ? 4'b0010 : 4'b0000);
            chk("burst_dv", data_valid, (i > 0) ? 4'b0010 : 4'b0000);
            tick();
        end
        chk("burst_dv_end", data_valid, 4'b0000);

        // Non-granted consumer gets are dropped
        for (int i = 0; i < 5; i++) begin
            data_get = 4'b0001;
            #1;
            chk("foreign_odg", out_ep_data_get, 4'b0000);
            chk("foreign_dv", data_valid, 4'b0000);
            chk("foreign_grant", out_ep_grant, 4'b0010);
            tick();
        end
        data_get = 4'b0000;
        chk("foreign_dv_end", data_valid, 4'b0000);

        // EP2: request falls in the same cycle as a get
        rotate(4'b1101, 4'b0100, 4'd2);
        req = 4'b1001;
        data_get = 4'b0100;
        #1;
        chk("lastget_odg", out_ep_data_get, 4'b0100);
        tick();
        data_get = 4'b0000;
        chk("lastget_rel_grant", out_ep_grant, 4'b0000);
        chk("lastget_rel_dv", data_valid, 4'b0100);
        chk("lastget_rel_busy", 4'(busy), 4'd1);
        tick();
        chk("lastget_idle_grant", out_ep_grant, 4'b0000);
        chk("lastget_idle_dv", data_valid, 4'b0000);
        tick();
        chk("lastget_next_grant", out_ep_grant, 4'b1000);
        chk("lastget_next_num", grant_num, 4'd3);

        // Reset while EP3 owns the port with a get in flight
        data_get = 4'b1000;
        #1;
        chk("pre_rst_odg", out_ep_data_get, 4'b1000);
        reset = 1'b1;
        tick();
        chk("midrst_grant", out_ep_grant, 4'b0000);
        chk("midrst_dv", data_valid, 4'b0000);
        chk("midrst_busy", 4'(busy), 4'd0);
        chk("midrst_num", grant_num, 4'd0);
        chk("midrst_odg", out_ep_data_get, 4'b0000);
        reset = 1'b0;
        data_get = 4'b0000;
        req = 4'b1001;
        tick();
        chk("ptr_restart_grant", out_ep_grant, 4'b0001);
        chk("ptr_restart_num", grant_num, 4'd0);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        req = 4'b1000;
        tick();
        chk("post_rst_grant", out_ep_grant, 4'b1000);
        chk("post_rst_num", grant_num, 4'd3);
        req = 4'b0000;

        // Single-endpoint instance: IDLE -> GRANTED -> RELEASE -> IDLE -> GRANTED
        req1 = 1'b1;
        tick();
        chk("n1_grant_a", 4'(grant1), 4'd1);
        chk("n1_num_a", gn1, 4'd0);
        req1 = 1'b0;
        tick();
        chk("n1_release", 4'(grant1), 4'd0);
        chk("n1_release_busy", 4'(busy1), 4'd1);
        req1 = 1'b1;
        tick();
        chk("n1_idle", 4'(grant1), 4'd0);
        chk("n1_idle_busy", 4'(busy1), 4'd0);
        tick();
        chk("n1_grant_b", 4'(grant1), 4'd1);
        data_get1 = 1'b1;
        #1;
        chk("n1_odg", 4'(odg1), 4'd1);
        tick();
        data_get1 = 1'b0;
        chk("n1_dv", 4'(dv1), 4'd1);

        armed = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
